dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the target side of the CPU's MEM-stage load/store interface.
- Accepts one read or write request at a time over a req/ready handshake.
- Models a fixed access latency and returns the read data or a write acknowledge with a one-cycle rsp_valid pulse.
- Lets the CPU move from a zero-latency data memory to a stall-aware one; the core stalls while ready is low or a response is pending.

Parameters:
ADDR_W, 12, word-address width; array depth = 2**ADDR_W 16-bit words
LATENCY, 4, cycles from request acceptance to response; legal range 1..15

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
req  input  1  request strobe; accepted when req && ready
we  input  1  1 = write, 0 = read; sampled with req
addr  input  16  byte address; word index = addr[ADDR_W:1]; upper bits ignored (aliasing)
wdata  input  16  store data; sampled with req
ready  output  1  high only in IDLE
rsp_valid  output  1  one-cycle completion pulse
rdata  output  16  load data; valid only while rsp_valid && the request was a read
err  output  1  alignment error flag (see Optional Feature)

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, ready=1, rsp_valid=0, rdata=0, err=0, counter=0, captured request registers=0.
  - The memory array is not reset.
- FSM states IDLE, BUSY, RESP:
  - IDLE: ready=1. On req, capture we, word index and wdata; load counter with LATENCY-1. If LATENCY==1 go to RESP, otherwise go to BUSY.
  - BUSY: ready=0. Decrement the counter each cycle; when it reads 0, go to RESP.
  - RESP: ready=0, rsp_valid=1 for exactly one cycle; then go to IDLE unconditionally.
- Timing:
  - Request accepted in cycle T gives rsp_valid high in cycle T+LATENCY.
  - ready returns high in cycle T+LATENCY+1, so back-to-back throughput is one request per LATENCY+1 cycles.
  - req while ready=0 is ignored; it is neither queued nor errored.
- Writes:
  - Array updated on the edge entering RESP.
  - A read accepted after the write's rsp_valid cycle always returns the new data.
- Reads:
  - rdata is registered on the edge entering RESP from the array at the captured index; it holds that value until the next response.
  - On a write response rdata=0.
- The array is read asynchronously and written synchronously; only this block writes it.
- Reset mid-operation: a pending request is dropped and no rsp_valid is issued. A write not yet committed is lost; one already committed remains.
- Input changes after acceptance have no effect; only the captured registers are used.

Optional Feature:
Macro DMEM_ALIGN_CHK_EN.
- Defined:
  - addr[0]=1 on an accepted request is a misaligned access.
  - The transaction still takes LATENCY cycles; err=1 together with rsp_valid.
  - A misaligned write does not modify the array; a misaligned read returns rdata=0.
- Undefined:
  - addr[0] is ignored, err is tied 0, and the access proceeds on the word index.

Decomposition:
- Package dmem_pkg holds:
  - WORD_W=16
  - the state enum {IDLE, BUSY, RESP}
  - LAT_CNT_W=4
- Sub-module dmem_array holds the 2**ADDR_W x WORD_W storage: synchronous write-enable port, asynchronous read port.
- The FSM, counter and capture registers stay in dmem_responder.

Test Plan:
- Reset with rst_n=0 asserted mid-BUSY, then released → ready=1, rsp_valid=0, rdata=0 immediately on assertion, with no response afterwards.
- Write, then read:
  - Write addr=0x0010, wdata=0xBEEF at cycle 5 with LATENCY=4 → rsp_valid at cycle 9, ready high at cycle 10.
  - Read of 0x0010 accepted at cycle 10 → rdata=0xBEEF with rsp_valid at cycle 14.
- req held high continuously with LATENCY=1 → accepts on alternating cycles only, rsp_valid every 2 cycles, no request lost or duplicated.
- req asserted while BUSY with we=1, addr=0x0020, wdata=0x1234 → ignored; a later read of 0x0020 returns the prior contents.
- Aliasing with ADDR_W=12:
  - Write 0xAAAA to addr 0x0002, then read addr 0x2002 → rdata=0xAAAA.
- DMEM_ALIGN_CHK_EN defined:
  - Write addr=0x0003, wdata=0x5555 → err=1 with rsp_valid, array unchanged.
  - Read addr=0x0001 → err=1, rdata=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Word width, latency counter width and the responder FSM states.
package dmem_pkg;

    localparam int WORD_W    = 16;
    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage for the responder.
// Synchronous write port, asynchronous read port, no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM-stage load/store port.
// Define DMEM_ALIGN_CHK_EN to flag and suppress misaligned (addr[0]) accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [15:0]       addr,
    input  logic [WORD_W-1:0] wdata,
    output logic              ready,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rdata,
    output logic              err
);

    localparam logic [LAT_CNT_W-1:0] CNT_INIT =
        LAT_CNT_W'(LATENCY - 1);

    state_t state, state_nxt;

    logic [LAT_CNT_W-1:0] cnt;
    logic [LAT_CNT_W-1:0] cnt_dec;

    logic              cap_we;
    logic              cap_mis;
    logic [ADDR_W-1:0] cap_idx;
    logic [WORD_W-1:0] cap_wdata;

    logic              accept;
    logic              go_resp;
    logic              mis;
    logic              sel_we;
    logic              sel_mis;
    logic [ADDR_W-1:0] sel_idx;
    logic [WORD_W-1:0] sel_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_wr;
    logic [WORD_W-1:0] rdata_q;
    logic              unused_addr;

`ifdef DMEM_ALIGN_CHK_EN
    assign mis = addr[0];
`else
    assign mis = 1'b0;
`endif

    // Upper address bits alias; bit 0 only matters with the check on.
    assign unused_addr = ^{addr[15:ADDR_W+1], addr[0]};

    assign accept  = req && (state == IDLE);
    assign cnt_dec = cnt - LAT_CNT_W'(1);
    assign go_resp = (state != RESP) && (state_nxt == RESP);

    // With LATENCY==1 the commit happens on the accepting edge,
    // before the capture registers hold the request.
    assign sel_we    = (state == IDLE) ? we    : cap_we;
    assign sel_mis   = (state == IDLE) ? mis   : cap_mis;
    assign sel_wdata = (state == IDLE) ? wdata : cap_wdata;
    assign sel_idx   = (state == IDLE) ? addr[ADDR_W:1] : cap_idx;

    assign mem_wr = go_resp && sel_we && !sel_mis;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .wr_en (mem_wr),
        .waddr (sel_idx),
        .wdata (sel_wdata),
        .raddr (sel_idx),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (cnt_dec == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready     = 1'b0;
        rsp_valid = 1'b0;
        err       = 1'b0;
        unique case (state)
            IDLE: ready = 1'b1;
            RESP: begin
                rsp_valid = 1'b1;
                err       = cap_mis;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_mis   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                cnt       <= CNT_INIT;
                cap_we    <= we;
                cap_mis   <= mis;
                cap_idx   <= addr[ADDR_W:1];
                cap_wdata <= wdata;
            end else if (state == BUSY) begin
                cnt <= cnt_dec;
            end
            if (go_resp) begin
                rdata_q <= (sel_we || sel_mis) ? '0 : mem_rdata;
            end
        end
    end

    assign rdata = rdata_q;

endmodule
